// File: rtl/ddr2_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_init_seq
// Description : DDR2 power-up / initialisation command sequencer with
//               programmable MR/EMR fields and init timings.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr2_init_seq #(
  parameter int NUM_RANKS      = 1,
  parameter int BA_WIDTH       = 3,
  parameter int ADDR_WIDTH     = 14,
  parameter int CAS_LATENCY    = 5,
  parameter int BURST_LEN      = 4,
  parameter int WRITE_RECOVERY = 6,
  parameter int RTT            = 0,
  parameter int DQS_N_DISABLE  = 1,
  parameter int T_INIT         = 200,
  parameter int T_NOP          = 40,
  parameter int T_RP           = 4,
  parameter int T_MRD          = 2,
  parameter int T_RFC          = 26,
  parameter int T_DLLK         = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cke_o,
  output logic [NUM_RANKS-1:0]  cs_n_o,
  output logic                  ras_n_o,
  output logic                  cas_n_o,
  output logic                  we_n_o,
  output logic [BA_WIDTH-1:0]   ba_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [NUM_RANKS-1:0]  odt_o
);

  function automatic int max_t();
    int m;
    m = T_INIT;
    if (T_NOP  > m) m = T_NOP;
    if (T_RP   > m) m = T_RP;
    if (T_MRD  > m) m = T_MRD;
    if (T_RFC  > m) m = T_RFC;
    if (T_DLLK > m) m = T_DLLK;
    return m;
  endfunction

  localparam int c_CNT_W = $clog2(max_t()) + 1;

  localparam logic [c_CNT_W-1:0] c_INIT_M1 = c_CNT_W'(T_INIT - 1);
  localparam logic [c_CNT_W-1:0] c_NOP_M1  = c_CNT_W'(T_NOP - 1);
  localparam logic [c_CNT_W-1:0] c_RP_M1   = c_CNT_W'(T_RP - 1);
  localparam logic [c_CNT_W-1:0] c_MRD_M1  = c_CNT_W'(T_MRD - 1);
  localparam logic [c_CNT_W-1:0] c_RFC_M1  = c_CNT_W'(T_RFC - 1);
  localparam logic [c_CNT_W-1:0] c_DLLK_M1 = c_CNT_W'(T_DLLK - 1);

  // A12..A0 images of the mode registers with DLL-reset / OCD fields cleared
  localparam logic [12:0] c_MR_BASE = {1'b0, 3'(WRITE_RECOVERY - 1), 1'b0, 1'b0,
                                       3'(CAS_LATENCY), 1'b0,
                                       (BURST_LEN == 8) ? 3'd3 : 3'd2};
  localparam logic [12:0] c_EMR_BASE = {2'b00, 1'(DQS_N_DISABLE), 3'b000,
                                        1'(RTT >> 1), 3'b000, 1'(RTT), 2'b00};

  if (CAS_LATENCY < 3 || CAS_LATENCY > 6) begin : g_bad_cl
    $error("ddr2_init_seq: illegal CAS_LATENCY");
  end
  if (WRITE_RECOVERY < 2 || WRITE_RECOVERY > 6) begin : g_bad_wr
    $error("ddr2_init_seq: illegal WRITE_RECOVERY");
  end
  if (BURST_LEN != 4 && BURST_LEN != 8) begin : g_bad_bl
    $error("ddr2_init_seq: illegal BURST_LEN");
  end
  if (T_INIT < 1 || T_NOP < 1 || T_RP < 1 || T_MRD < 1 || T_RFC < 1 || T_DLLK < 1) begin : g_bad_t
    $error("ddr2_init_seq: timing parameter below 1");
  end
  if (ADDR_WIDTH < 13) begin : g_bad_aw
    $error("ddr2_init_seq: ADDR_WIDTH below 13");
  end

  // Steps: 0 PREA, 1 EMR2, 2 EMR3, 3 EMR, 4 MR_DLLRST, 5 PREA, 6 REF, 7 REF,
  //        8 MR, 9 EMR_OCD_DEF, 10 EMR_OCD_EXIT
  function automatic logic [2:0] step_rcw(input logic [3:0] s);
    case (s)
      4'd0, 4'd5: return 3'b010;
      4'd6, 4'd7: return 3'b001;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] step_ba(input logic [3:0] s);
    case (s)
      4'd1:              return 2'd2;
      4'd2:              return 2'd3;
      4'd3, 4'd9, 4'd10: return 2'd1;
      default:           return 2'd0;
    endcase
  endfunction

  function automatic logic [12:0] step_addr(input logic [3:0] s);
    case (s)
      4'd0, 4'd5:  return 13'h0400;
      4'd3, 4'd10: return c_EMR_BASE;
      4'd4:        return c_MR_BASE | 13'h0100;
      4'd8:        return c_MR_BASE;
      4'd9:        return c_EMR_BASE | 13'h0380;
      default:     return 13'h0000;
    endcase
  endfunction

  function automatic logic [c_CNT_W-1:0] step_gap_m1(input logic [3:0] s);
    case (s)
      4'd0, 4'd5: return c_RP_M1;
      4'd6, 4'd7: return c_RFC_M1;
      default:    return c_MRD_M1;
    endcase
  endfunction

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CKE_LOW  = 3'd1,
    S_NOP      = 3'd2,
    S_CMD      = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t               r_state;
  logic [3:0]           r_step;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   r_dllk;
  logic                 r_busy, r_done, r_cke;
  logic [NUM_RANKS-1:0] r_cs_n;
  logic [2:0]           r_rcw;
  logic [BA_WIDTH-1:0]  r_ba;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic       w_gap_met;
  logic       w_ready;
  logic [3:0] w_next_step;

  always_comb begin
    w_next_step = r_step + 4'd1;
    w_gap_met   = (r_cnt >= step_gap_m1(r_step));
    // The OCD-default EMR must also wait out DLL lock after MR_DLLRST
    w_ready     = w_gap_met && ((r_step != 4'd8) || (r_dllk >= c_DLLK_M1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_step  <= 4'd0;
      r_cnt   <= '0;
      r_dllk  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cke   <= 1'b0;
      r_cs_n  <= '1;
      r_rcw   <= 3'b111;
      r_ba    <= '0;
      r_addr  <= '0;
    end else begin
      if (r_dllk != '1) r_dllk <= r_dllk + 1'b1;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_state <= S_CKE_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_cke   <= 1'b0;
            r_cs_n  <= '1;
            r_rcw   <= 3'b111;
            r_ba    <= '0;
            r_addr  <= '0;
          end
        end
        S_CKE_LOW: begin
          if (r_cnt == c_INIT_M1) begin
            r_state <= S_NOP;
            r_cnt   <= '0;
            r_cke   <= 1'b1;
            r_cs_n  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_NOP: begin
          if (r_cnt == c_NOP_M1) begin
            r_state <= S_CMD;
            r_step  <= 4'd0;
            r_cnt   <= '0;
            r_rcw   <= step_rcw(4'd0);
            r_ba    <= BA_WIDTH'(step_ba(4'd0));
            r_addr  <= ADDR_WIDTH'(step_addr(4'd0));
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CMD: begin
          if (w_ready && r_step == 4'd10) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cs_n  <= '1;
            r_rcw   <= 3'b111;
            r_ba    <= '0;
            r_addr  <= '0;
          end else if (w_ready) begin
            r_step <= w_next_step;
            r_cnt  <= '0;
            r_rcw  <= step_rcw(w_next_step);
            r_ba   <= BA_WIDTH'(step_ba(w_next_step));
            r_addr <= ADDR_WIDTH'(step_addr(w_next_step));
            if (w_next_step == 4'd4) r_dllk <= '0;
          end else begin
            r_rcw  <= 3'b111;
            r_ba   <= '0;
            r_addr <= '0;
            if (!w_gap_met) r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign cke_o   = r_cke;
  assign cs_n_o  = r_cs_n;
  assign ras_n_o = r_rcw[2];
  assign cas_n_o = r_rcw[1];
  assign we_n_o  = r_rcw[0];
  assign ba_o    = r_ba;
  assign addr_o  = r_addr;
  assign odt_o   = '0;

endmodule
`default_nettype wire

// File: tb/tb_ddr2_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr2_init_seq
// Description : Scoreboard bench for ddr2_init_seq (default and alternate
//               parameter sets driven side by side).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ddr2_init_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  always #5 clk = ~clk;

  logic        a_busy, a_done, a_cke, a_cs_n, a_ras, a_cas, a_we, a_odt;
  logic [2:0]  a_ba;
  logic [13:0] a_addr;
  logic        b_busy, b_done, b_cke, b_ras, b_cas, b_we;
  logic [1:0]  b_cs_n, b_odt;
  logic [2:0]  b_ba;
  logic [13:0] b_addr;

  ddr2_init_seq u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(a_busy), .done_o(a_done),
    .cke_o(a_cke), .cs_n_o(a_cs_n), .ras_n_o(a_ras), .cas_n_o(a_cas), .we_n_o(a_we),
    .ba_o(a_ba), .addr_o(a_addr), .odt_o(a_odt)
  );

  ddr2_init_seq #(
    .NUM_RANKS(2), .BURST_LEN(8), .CAS_LATENCY(4), .WRITE_RECOVERY(4),
    .RTT(1), .DQS_N_DISABLE(0), .T_DLLK(10)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(b_busy), .done_o(b_done),
    .cke_o(b_cke), .cs_n_o(b_cs_n), .ras_n_o(b_ras), .cas_n_o(b_cas), .we_n_o(b_we),
    .ba_o(b_ba), .addr_o(b_addr), .odt_o(b_odt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {cycle, ras/cas/we, ba, addr}
  typedef logic [35:0] ev_t;
  ev_t qa[$];
  ev_t qb[$];

  function automatic ev_t mk(input int cyc, input logic [2:0] rcw,
                             input logic [2:0] ba, input logic [13:0] addr);
    return {16'(cyc), rcw, ba, addr};
  endfunction

  task automatic push_seq(input bit sel_b, input logic [13:0] mr_dll, input logic [13:0] mr,
                          input logic [13:0] emr, input int ocd);
    ev_t ev[11];
    ev[0]  = mk(240, 3'b010, 3'd0, 14'h0400);
    ev[1]  = mk(244, 3'b000, 3'd2, 14'h0000);
    ev[2]  = mk(246, 3'b000, 3'd3, 14'h0000);
    ev[3]  = mk(248, 3'b000, 3'd1, emr);
    ev[4]  = mk(250, 3'b000, 3'd0, mr_dll);
    ev[5]  = mk(252, 3'b010, 3'd0, 14'h0400);
    ev[6]  = mk(256, 3'b001, 3'd0, 14'h0000);
    ev[7]  = mk(282, 3'b001, 3'd0, 14'h0000);
    ev[8]  = mk(308, 3'b000, 3'd0, mr);
    ev[9]  = mk(ocd, 3'b000, 3'd1, emr | 14'h0380);
    ev[10] = mk(ocd + 2, 3'b000, 3'd1, emr);
    for (int i = 0; i < 11; i++) begin
      if (sel_b) qb.push_back(ev[i]);
      else       qa.push_back(ev[i]);
    end
  endtask

  task automatic run_seq(input int abort_at);
    push_seq(1'b0, 14'h0B52, 14'h0A52, 14'h0400, 450);
    push_seq(1'b1, 14'h0743, 14'h0643, 14'h0004, 310);
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c <= 460; c++) begin
      @(negedge clk);
      if (c == 0 || c == 101 || c == 301) start = 1'b0;
      if (c == 100 || c == 300) start = 1'b1;
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_val("abort_cke",  a_cke,  0);
        check_val("abort_csn",  a_cs_n, 1);
        check_val("abort_busy", a_busy, 0);
        check_val("abort_rcw",  {a_ras, a_cas, a_we}, 3'b111);
        check_val("abort_b_csn", b_cs_n, 2'b11);
        qa.delete();
        qb.delete();
        return;
      end
      if (a_cs_n != 1'b1 && {a_ras, a_cas, a_we} != 3'b111) begin
        if (qa.size() == 0) check_val("a_extra_cmd", c, 0);
        else check_val("a_cmd", mk(c, {a_ras, a_cas, a_we}, a_ba, a_addr), qa.pop_front());
      end
      if (b_cs_n != 2'b11 && {b_ras, b_cas, b_we} != 3'b111) begin
        check_val("b_csn_cmd", b_cs_n, 2'b00);
        if (qb.size() == 0) check_val("b_extra_cmd", c, 0);
        else check_val("b_cmd", mk(c, {b_ras, b_cas, b_we}, b_ba, b_addr), qb.pop_front());
      end
      case (c)
        0: begin
          check_val("c0_cke",  a_cke,  0);
          check_val("c0_busy", a_busy, 1);
          check_val("c0_done", a_done, 0);
          check_val("c0_csn",  a_cs_n, 1);
        end
        199: check_val("c199_cke", a_cke, 0);
        200: begin
          check_val("c200_cke",   a_cke, 1);
          check_val("c200_nop",   {a_cs_n, a_ras, a_cas, a_we}, 4'b0111);
          check_val("c200_b_csn", b_cs_n, 2'b00);
        end
        250: check_val("odt", {a_odt, b_odt}, 3'b000);
        313: check_val("b_done_early", b_done, 0);
        314: begin
          check_val("b_done", {b_busy, b_done, b_cke, b_cs_n}, 5'b01111);
        end
        453: check_val("a_done_early", {a_busy, a_done}, 2'b10);
        454: check_val("a_done", {a_busy, a_done, a_cke, a_cs_n}, 4'b0111);
        default: ;
      endcase
    end
    check_val("a_queue_left", qa.size(), 0);
    check_val("b_queue_left", qb.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_cke",   a_cke,  0);
    check_val("rst_csn",   a_cs_n, 1);
    check_val("rst_busy",  a_busy, 0);
    check_val("rst_done",  a_done, 0);
    check_val("rst_b_csn", b_cs_n, 2'b11);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_seq(-1);
    run_seq(-1);
    run_seq(270);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_val("idle_after_rst", {a_busy, a_done, a_cke, a_cs_n}, 4'b0001);
    check_val("idle_rcw", {a_ras, a_cas, a_we}, 3'b111);
    run_seq(-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
